// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares instruction RAM port B (word address, byte write enables, 32-bit data,
//   1-cycle synchronous read) between requester 0 (debug host) and requester 1
//   (program loader / self-test engine). Round-robin arbitration with burst lock;
//   read data is returned to the issuing requester the cycle after issue.
// Ports (requester i fields are packed at [i*W +: W]):
//   clk_i, rst_i              clock, synchronous active-high reset
//   rq_valid_i/rq_ready_o     per-requester request handshake (ready = grant)
//   rq_lock_i                 keep grant after this transfer (burst continues)
//   rq_addr_i/we_i/wdata_i    per-requester word address, byte enables, write data
//   rs_valid_o/rs_rdata_o     per-requester read-response strobe, shared read data
//   mem_addr_o/we_o/wdata_o   to RAM port B
//   mem_rdata_i               from RAM port B, valid the cycle after the address
module imem_port_arbiter #(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          rq_valid_i,
  output logic [1:0]          rq_ready_o,
  input  logic [1:0]          rq_lock_i,
  input  logic [2*AW-1:0]     rq_addr_i,
  input  logic [2*(DW/8)-1:0] rq_we_i,
  input  logic [2*DW-1:0]     rq_wdata_i,
  output logic [1:0]          rs_valid_o,
  output logic [DW-1:0]       rs_rdata_o,
  output logic [AW-1:0]       mem_addr_o,
  output logic [DW/8-1:0]     mem_we_o,
  output logic [DW-1:0]       mem_wdata_o,
  input  logic [DW-1:0]       mem_rdata_i
);

  localparam int BW = DW / 8;

  logic last_grant_q, last_grant_d;
  logic locked_q, locked_d;
  logic lock_owner_q, lock_owner_d;
  logic rs_pend_q, rs_pend_d;
  logic rs_owner_q, rs_owner_d;

  logic          gnt_idx;
  logic          xfer;
  logic          sel;
  logic [BW-1:0] sel_we;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      locked_q     <= 1'b0;
      lock_owner_q <= 1'b0;
      rs_pend_q    <= 1'b0;
      rs_owner_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      rs_pend_q    <= rs_pend_d;
      rs_owner_q   <= rs_owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
    rs_pend_d    = 1'b0;
    rs_owner_d   = rs_owner_q;
    if (xfer) begin
      last_grant_d = gnt_idx;
      // A transfer by the owner without lock ends the burst in the same cycle.
      locked_d     = rq_lock_i[gnt_idx];
      lock_owner_d = gnt_idx;
      rs_pend_d    = (sel_we == '0);
      rs_owner_d   = gnt_idx;
    end
  end

  // Output logic: arbitration, memory mux, response routing
  always_comb begin
    gnt_idx = 1'b0;
    xfer    = 1'b0;
    if (!rst_i) begin
      if (locked_q) begin
        // Owner keeps the port even while idle; the other side waits.
        gnt_idx = lock_owner_q;
        xfer    = rq_valid_i[lock_owner_q];
      end else if (&rq_valid_i) begin
        gnt_idx = ~last_grant_q;
        xfer    = 1'b1;
      end else if (rq_valid_i[1]) begin
        gnt_idx = 1'b1;
        xfer    = 1'b1;
      end else begin
        gnt_idx = 1'b0;
        xfer    = rq_valid_i[0];
      end
    end

    // Idle cycles drive requester 0 fields onto the memory bus.
    sel         = xfer & gnt_idx;
    sel_we      = sel ? rq_we_i[BW +: BW] : rq_we_i[0 +: BW];
    mem_addr_o  = sel ? rq_addr_i[AW +: AW] : rq_addr_i[0 +: AW];
    mem_wdata_o = sel ? rq_wdata_i[DW +: DW] : rq_wdata_i[0 +: DW];
    mem_we_o    = xfer ? sel_we : '0;

    rq_ready_o    = 2'b00;
    rq_ready_o[0] = xfer & ~gnt_idx;
    rq_ready_o[1] = xfer & gnt_idx;

    // Gated by rst_i so a read issued just before reset returns nothing.
    rs_valid_o    = 2'b00;
    rs_valid_o[0] = rs_pend_q & ~rs_owner_q & ~rst_i;
    rs_valid_o[1] = rs_pend_q & rs_owner_q & ~rst_i;
    rs_rdata_o    = mem_rdata_i;
  end

endmodule
